// File: rtl/lsu.sv
// Load/store unit: one outstanding memory access, with byte-lane steering and load extension.
// Optional macro LSU_MISALIGN_CHECK_EN traps misaligned half/word accesses.
module lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            load,
    input  logic            store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            req_ready,
    output logic            stall,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wen,
    output logic [3:0]      mem_wmask,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic            misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [2:0]      funct3_q;
    logic            is_store_q;

    logic            accept;
    logic            misaligned_req;
    logic [3:0]      store_mask;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] rdata_shifted;
    logic [XLEN-1:0] load_ext;

    // rst gates accept so stall reads 0 while reset is held with a request pending
    assign accept = (state == IDLE) && req_valid && (load ^ store) && !rst;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned_req = ((funct3[1:0] == 2'b01) && addr[0]) ||
                            (funct3[1] && (addr[1:0] != 2'b00));
`else
    assign misaligned_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = misaligned_req ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_next = is_store_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= 3'b000;
            is_store_q <= 1'b0;
        end else if (accept) begin
            addr_q     <= addr;
            wdata_q    <= wdata;
            funct3_q   <= funct3;
            is_store_q <= store;
        end
    end

    always_comb begin
        store_mask = 4'b1111;
        store_data = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                store_mask = 4'b0001 << addr_q[1:0];
                store_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                store_mask = 4'b0011 << {addr_q[1], 1'b0};
                store_data = {2{wdata_q[15:0]}};
            end
            default: begin
                store_mask = 4'b1111;
                store_data = wdata_q;
            end
        endcase
    end

    assign rdata_shifted = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = rdata_shifted;
        case (funct3_q)
            3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b100:  load_ext = {24'd0, rdata_shifted[7:0]};
            3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b101:  load_ext = {16'd0, rdata_shifted[15:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    // resp_data only changes when a load completes or a trapped access reports zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data <= '0;
        end else if ((state == WAIT) && mem_rvalid) begin
            resp_data <= load_ext;
        end else if (accept && misaligned_req) begin
            resp_data <= '0;
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (accept && misaligned_req) begin
            misalign_q <= 1'b1;
        end else if (state == DONE) begin
            misalign_q <= 1'b0;
        end
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    // Memory-side outputs are zero outside REQ so reset drops them immediately
    assign req_ready  = (state == IDLE);
    assign stall      = accept || (state == REQ) || (state == WAIT);
    assign mem_valid  = (state == REQ);
    assign mem_addr   = (state == REQ) ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_wen    = (state == REQ) && is_store_q;
    assign mem_wmask  = ((state == REQ) && is_store_q) ? store_mask : 4'b0000;
    assign mem_wdata  = ((state == REQ) && is_store_q) ? store_data : '0;
    assign resp_valid = (state == DONE);

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: table of directed load/store vectors plus hand-written
// sequences for wait states, reset mid-access, illegal requests and misaligned words.
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        load;
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        req_ready;
    logic        stall;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        misalign;

    int total_cnt;
    int pass_cnt;

    typedef struct {
        logic        is_store;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_resp;
    } vec_t;

    vec_t vecs[10];

    lsu #(.XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .load(load),
        .store(store),
        .funct3(funct3),
        .addr(addr),
        .wdata(wdata),
        .req_ready(req_ready),
        .stall(stall),
        .mem_valid(mem_valid),
        .mem_addr(mem_addr),
        .mem_wen(mem_wen),
        .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .resp_valid(resp_valid),
        .resp_data(resp_data),
        .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        req_valid = 1'b0;
        load      = 1'b0;
        store     = 1'b0;
        funct3    = 3'b000;
        addr      = 32'd0;
        wdata     = 32'd0;
    endtask

    task automatic presentReq(input logic is_store, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        load      = !is_store;
        store     = is_store;
        funct3    = f3;
        addr      = a;
        wdata     = d;
    endtask

    // One full transaction with memory answering immediately
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        presentReq(v.is_store, v.funct3, v.addr, v.wdata);
        #1;
        checkOutput({tag, "_accept_stall"}, {31'd0, stall}, 32'd1);
        tick();
        clearInputs();
        mem_ready = 1'b1;
        #1;
        checkOutput({tag, "_mem_valid"}, {31'd0, mem_valid}, 32'd1);
        checkOutput({tag, "_mem_addr"}, mem_addr, v.exp_addr);
        checkOutput({tag, "_mem_wen"}, {31'd0, mem_wen}, {31'd0, v.is_store});
        if (v.is_store) begin
            checkOutput({tag, "_wmask"}, {28'd0, mem_wmask}, {28'd0, v.exp_mask});
            checkOutput({tag, "_wdata"}, mem_wdata, v.exp_wdata);
        end
        tick();
        mem_ready = 1'b0;
        if (!v.is_store) begin
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
            #1;
            checkOutput({tag, "_wait_stall"}, {31'd0, stall}, 32'd1);
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'd0;
        end
        #1;
        checkOutput({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
        checkOutput({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
        if (!v.is_store) begin
            checkOutput({tag, "_resp_data"}, resp_data, v.exp_resp);
        end
        tick();
        checkOutput({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
        checkOutput({tag, "_resp_pulse"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        total_cnt  = 0;
        pass_cnt   = 0;
        clearInputs();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        rst        = 1'b1;

        vecs[0] = '{1'b0, 3'b000, 32'h8000_0002, 32'd0, 32'h00F0_0000, 32'h8000_0000, 4'b0000, 32'd0, 32'hFFFF_FFF0};
        vecs[1] = '{1'b0, 3'b101, 32'h8000_0002, 32'd0, 32'h8001_ABCD, 32'h8000_0000, 4'b0000, 32'd0, 32'h0000_8001};
        vecs[2] = '{1'b0, 3'b001, 32'h8000_0000, 32'd0, 32'h1234_8765, 32'h8000_0000, 4'b0000, 32'd0, 32'hFFFF_8765};
        vecs[3] = '{1'b0, 3'b100, 32'h8000_0001, 32'd0, 32'h0000_AB00, 32'h8000_0000, 4'b0000, 32'd0, 32'h0000_00AB};
        vecs[4] = '{1'b0, 3'b010, 32'h8000_0008, 32'd0, 32'hCAFE_F00D, 32'h8000_0008, 4'b0000, 32'd0, 32'hCAFE_F00D};
        vecs[5] = '{1'b0, 3'b000, 32'h8000_0001, 32'd0, 32'h0000_7F00, 32'h8000_0000, 4'b0000, 32'd0, 32'h0000_007F};
        vecs[6] = '{1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 32'd0, 32'h8000_0000, 4'b1000, 32'hABAB_ABAB, 32'd0};
        vecs[7] = '{1'b1, 3'b001, 32'h8000_0002, 32'h1234_CAFE, 32'd0, 32'h8000_0000, 4'b1100, 32'hCAFE_CAFE, 32'd0};
        vecs[8] = '{1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'd0, 32'h8000_0004, 4'b1111, 32'hDEAD_BEEF, 32'd0};
        vecs[9] = '{1'b1, 3'b000, 32'h8000_0000, 32'h1122_3344, 32'd0, 32'h8000_0000, 4'b0001, 32'h4444_4444, 32'd0};

        // Reset state
        #2;
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_resp_data", resp_data, 32'd0);
        checkOutput("rst_misalign", {31'd0, misalign}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], i);
        end
        // Stores leave the last load result untouched
        checkOutput("resp_data_hold", resp_data, 32'h0000_007F);

        // Illegal request encodings are ignored
        presentReq(1'b0, 3'b010, 32'h8000_0010, 32'd0);
        load = 1'b1;
        store = 1'b1;
        #1;
        checkOutput("both_stall", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("both_mem_valid", {31'd0, mem_valid}, 32'd0);
        checkOutput("both_ready", {31'd0, req_ready}, 32'd1);
        load = 1'b0;
        store = 1'b0;
        #1;
        checkOutput("none_stall", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("none_mem_valid", {31'd0, mem_valid}, 32'd0);
        checkOutput("none_ready", {31'd0, req_ready}, 32'd1);
        clearInputs();
        tick();

        // LB with rvalid three cycles late
        presentReq(1'b0, 3'b000, 32'h8000_0002, 32'd0);
        tick();
        clearInputs();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("late_wait%0d_stall", i), {31'd0, stall}, 32'd1);
            checkOutput($sformatf("late_wait%0d_resp", i), {31'd0, resp_valid}, 32'd0);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h00F0_0000;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        checkOutput("late_resp_valid", {31'd0, resp_valid}, 32'd1);
        checkOutput("late_resp_data", resp_data, 32'hFFFF_FFF0);
        tick();

        // Store held in REQ while memory is busy
        presentReq(1'b1, 3'b010, 32'h8000_0020, 32'h0102_0304);
        tick();
        clearInputs();
        for (int i = 0; i < 2; i++) begin
            #1;
            checkOutput($sformatf("busy%0d_mem_valid", i), {31'd0, mem_valid}, 32'd1);
            checkOutput($sformatf("busy%0d_mem_addr", i), mem_addr, 32'h8000_0020);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checkOutput("busy_resp_valid", {31'd0, resp_valid}, 32'd1);
        tick();

        // Reset during REQ drops mem_valid immediately
        presentReq(1'b1, 3'b010, 32'h8000_0030, 32'h5555_AAAA);
        tick();
        clearInputs();
        checkOutput("rreq_mem_valid", {31'd0, mem_valid}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rreq_drop", {31'd0, mem_valid}, 32'd0);
        checkOutput("rreq_ready", {31'd0, req_ready}, 32'd1);
        tick();
        rst = 1'b0;
        tick();

        // Reset during WAIT, then a stale rvalid
        presentReq(1'b0, 3'b010, 32'h8000_0040, 32'd0);
        tick();
        clearInputs();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checkOutput("rwait_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rwait_stall_rst", {31'd0, stall}, 32'd0);
        checkOutput("rwait_ready_rst", {31'd0, req_ready}, 32'd1);
        tick();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        checkOutput("rwait_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rwait_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rwait_resp_data", resp_data, 32'd0);
        tick();
        checkOutput("rwait_resp_valid2", {31'd0, resp_valid}, 32'd0);

        // Misaligned LW
        presentReq(1'b0, 3'b010, 32'h8000_0001, 32'd0);
        tick();
        clearInputs();
`ifdef LSU_MISALIGN_CHECK_EN
        checkOutput("mis_mem_valid", {31'd0, mem_valid}, 32'd0);
        checkOutput("mis_flag", {31'd0, misalign}, 32'd1);
        checkOutput("mis_resp_valid", {31'd0, resp_valid}, 32'd1);
        checkOutput("mis_resp_data", resp_data, 32'd0);
        tick();
        checkOutput("mis_flag_clear", {31'd0, misalign}, 32'd0);
`else
        checkOutput("mis_mem_valid", {31'd0, mem_valid}, 32'd1);
        checkOutput("mis_mem_addr", mem_addr, 32'h8000_0000);
        checkOutput("mis_flag", {31'd0, misalign}, 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hAABB_CCDD;
        tick();
        mem_rvalid = 1'b0;
        checkOutput("mis_resp_valid", {31'd0, resp_valid}, 32'd1);
        checkOutput("mis_flag_done", {31'd0, misalign}, 32'd0);
        tick();
`endif
        checkOutput("final_ready", {31'd0, req_ready}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
